// File: rtl/gb_video_pkg.sv
// Shared video constants and write-scheduler FSM encoding for the line-store path.
package gb_video_pkg;

  localparam int GB_LINE_PIXELS   = 160;
  localparam int GB_VISIBLE_LINES = 144;

  localparam int STATE_W = 3;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETUP  = 3'd1;
  localparam logic [2:0] ST_GUARD  = 3'd2;
  localparam logic [2:0] ST_STROBE = 3'd3;
  localparam logic [2:0] ST_RETIRE = 3'd4;

endpackage

// File: rtl/line_fifo.sv
// Two-entry FIFO; a push while full is taken only when a pop happens in the same cycle.
module line_fifo #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;
  logic         push_ok;
  logic         pop_ok;

  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);
  assign data_o  = mem_q[rd_ptr_q];

  assign push_ok = push_i && (!full_o || pop_i);
  assign pop_ok  = pop_i && !empty_o;

  // Push+pop when full writes the slot being read out this same cycle, which is safe.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_ok) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/line_write_scheduler.sv
// Accepts completed PPU lines into a 2-deep queue and writes them into the VGA line
// store, stalling while the target line is the one currently being scanned out.
module line_write_scheduler
  import gb_video_pkg::*;
#(
  parameter int LINE_PIXELS   = GB_LINE_PIXELS,
  parameter int VISIBLE_LINES = GB_VISIBLE_LINES
) (
  input  logic                   pixelClk,
  input  logic                   reset,
  input  logic [7:0]             LY,
  input  logic                   lineReq,
  input  logic [LINE_PIXELS-1:0] lineData0,
  input  logic [LINE_PIXELS-1:0] lineData1,
  output logic                   lineAck,
  input  logic [9:0]             VCount,
  output logic [7:0]             rdAddr,
  output logic                   lineValid,
  output logic                   wrEn,
  output logic [7:0]             wrAddr,
  output logic [LINE_PIXELS-1:0] wrData0,
  output logic [LINE_PIXELS-1:0] wrData1,
  output logic                   busy,
  output logic                   frameDone,
  output logic [STATE_W-1:0]     dbgState
);

  localparam int         ENTRY_W   = 8 + 2 * LINE_PIXELS;
  localparam logic [8:0] VIS_LY    = 9'(VISIBLE_LINES);
  localparam logic [9:0] VIS_VC    = 10'(VISIBLE_LINES);
  localparam logic [7:0] LAST_LINE = 8'(VISIBLE_LINES - 1);

  // Handshake: lineReq is a level held with LY/data stable until lineAck pulses for
  // one cycle; the request is ignored on the cycle lineAck is high so one offer is
  // never consumed twice.
  logic                   ack_q, ack_d;
  logic [7:0]             last_ly_q, last_ly_d;
  logic [STATE_W-1:0]     state_q, state_d;
  logic [7:0]             wr_addr_q;
  logic [LINE_PIXELS-1:0] wr_data0_q;
  logic [LINE_PIXELS-1:0] wr_data1_q;

  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [ENTRY_W-1:0] fifo_head;
  logic               load_head;
  logic               guard_hit;
  logic               req_live;
  logic               ly_out_of_range;
  logic               ly_dup;

  line_fifo #(.W(ENTRY_W)) u_fifo (
    .clk_i   (pixelClk),
    .rst_i   (reset),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .data_i  ({LY, lineData0, lineData1}),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign lineValid = (VCount < VIS_VC);
  assign rdAddr    = lineValid ? VCount[7:0] : 8'd0;

  assign req_live        = lineReq && !ack_q;
  assign ly_out_of_range = ({1'b0, LY} >= VIS_LY);
  assign ly_dup          = (LY == last_ly_q);

  always_comb begin
    ack_d     = 1'b0;
    fifo_push = 1'b0;
    last_ly_d = last_ly_q;
    if (req_live) begin
      if (ly_out_of_range || ly_dup) begin
        ack_d = 1'b1;
      end else if (!fifo_full || fifo_pop) begin
        ack_d     = 1'b1;
        fifo_push = 1'b1;
        last_ly_d = LY;
      end
    end
  end

  assign guard_hit = lineValid && (wr_addr_q == rdAddr);
  assign fifo_pop  = (state_q == ST_RETIRE);

  always_comb begin
    state_d   = state_q;
    load_head = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_d   = ST_SETUP;
          load_head = 1'b1;
        end
      end
      ST_SETUP:  state_d = guard_hit ? ST_GUARD : ST_STROBE;
      ST_GUARD:  state_d = guard_hit ? ST_GUARD : ST_STROBE;
      ST_STROBE: state_d = ST_RETIRE;
      ST_RETIRE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pixelClk or posedge reset) begin
    if (reset) begin
      ack_q      <= 1'b0;
      last_ly_q  <= 8'hFF;
      state_q    <= ST_IDLE;
      wr_addr_q  <= 8'd0;
      wr_data0_q <= '0;
      wr_data1_q <= '0;
    end else begin
      ack_q     <= ack_d;
      last_ly_q <= last_ly_d;
      state_q   <= state_d;
      if (load_head) begin
        wr_addr_q  <= fifo_head[ENTRY_W-1 -: 8];
        wr_data0_q <= fifo_head[2*LINE_PIXELS-1 -: LINE_PIXELS];
        wr_data1_q <= fifo_head[LINE_PIXELS-1:0];
      end
    end
  end

  assign lineAck   = ack_q;
  assign wrEn      = (state_q == ST_STROBE);
  assign wrAddr    = wr_addr_q;
  assign wrData0   = wr_data0_q;
  assign wrData1   = wr_data1_q;
  assign busy      = !fifo_empty || (state_q != ST_IDLE);
  assign frameDone = fifo_pop && (wr_addr_q == LAST_LINE);
  assign dbgState  = state_q;

endmodule

// File: tb/tb_line_write_scheduler.sv
// Scenario bench for line_write_scheduler: expected line-store writes are queued when
// a line is accepted and checked as each wrEn pulse appears.
module tb_line_write_scheduler;
  import gb_video_pkg::*;

  localparam int LP = 160;
  localparam int VL = 144;
  localparam int W  = 8 + 2 * LP;

  logic          pixelClk = 1'b0;
  logic          reset;
  logic [7:0]    LY;
  logic          lineReq;
  logic [LP-1:0] lineData0;
  logic [LP-1:0] lineData1;
  logic          lineAck;
  logic [9:0]    VCount;
  logic [7:0]    rdAddr;
  logic          lineValid;
  logic          wrEn;
  logic [7:0]    wrAddr;
  logic [LP-1:0] wrData0;
  logic [LP-1:0] wrData1;
  logic          busy;
  logic          frameDone;
  logic [2:0]    dbgState;

  int vectors = 0;
  int errors  = 0;
  int wr_count = 0;
  int exp_writes = 0;
  logic [W-1:0] exp_q[$];

  line_write_scheduler #(.LINE_PIXELS(LP), .VISIBLE_LINES(VL)) dut (
    .pixelClk (pixelClk),
    .reset    (reset),
    .LY       (LY),
    .lineReq  (lineReq),
    .lineData0(lineData0),
    .lineData1(lineData1),
    .lineAck  (lineAck),
    .VCount   (VCount),
    .rdAddr   (rdAddr),
    .lineValid(lineValid),
    .wrEn     (wrEn),
    .wrAddr   (wrAddr),
    .wrData0  (wrData0),
    .wrData1  (wrData1),
    .busy     (busy),
    .frameDone(frameDone),
    .dbgState (dbgState)
  );

  // ---------------- clock / reset ----------------
  always #5 pixelClk = ~pixelClk;

  task automatic tick();
    @(posedge pixelClk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    lineReq   = 1'b0;
    LY        = 8'd0;
    lineData0 = '0;
    lineData1 = '0;
    VCount    = 10'd300;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge pixelClk) begin
    if (!reset && wrEn) begin
      logic [W-1:0] exp;
      wr_count++;
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected: got write addr=%0d, expected no write", wrAddr);
      end else begin
        exp = exp_q.pop_front();
        if ({wrAddr, wrData0, wrData1} !== exp) begin
          errors++;
          $display("FAIL wr_line: got addr=%0d d0=%h, expected addr=%0d d0=%h",
                   wrAddr, wrData0, exp[W-1 -: 8], exp[2*LP-1 -: LP]);
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic rand_data();
    for (int i = 0; i < LP; i++) begin
      lineData0[i] = 1'($urandom_range(0, 1));
      lineData1[i] = 1'($urandom_range(0, 1));
    end
  endtask

  // Offer one line and wait for its ack; queue the expected write if it should be stored.
  task automatic offer(input logic [7:0] ly, input bit expect_push);
    bit got = 1'b0;
    LY = ly;
    rand_data();
    lineReq = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (lineAck === 1'b1) got = 1'b1;
    end
    vectors++;
    if (!got) begin
      errors++;
      $display("FAIL offer_ack_timeout: LY=%0d got no lineAck, expected one within 20 cycles", ly);
    end else if (expect_push) begin
      exp_q.push_back({ly, lineData0, lineData1});
      exp_writes++;
    end
    lineReq = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      tick();
      if (busy === 1'b0) done = 1'b1;
    end
    vectors++;
    if (!done) begin
      errors++;
      $display("FAIL idle_timeout: busy=%b, expected 0 within 40 cycles", busy);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    lineReq = 1'b0;
    LY = 8'd0;
    lineData0 = '0;
    lineData1 = '0;
    VCount = 10'd20;
    tick();
    vectors++;
    if ({lineAck, wrEn, busy, frameDone, dbgState} !== {4'b0000, ST_IDLE}) begin
      errors++;
      $display("FAIL reset_ctrl: got ack/wr/busy/fd/state=%b, expected 0000_000",
               {lineAck, wrEn, busy, frameDone, dbgState});
    end
    vectors++;
    if ({wrAddr, wrData0, wrData1} !== '0) begin
      errors++;
      $display("FAIL reset_wrport: got addr=%0d, expected 0 with zero data", wrAddr);
    end
    vectors++;
    if (rdAddr !== 8'd20 || lineValid !== 1'b1) begin
      errors++;
      $display("FAIL rd_visible: got rdAddr=%0d valid=%b, expected 20/1", rdAddr, lineValid);
    end
    VCount = 10'd144;
    #1;
    vectors++;
    if (rdAddr !== 8'd0 || lineValid !== 1'b0) begin
      errors++;
      $display("FAIL rd_blank: got rdAddr=%0d valid=%b, expected 0/0", rdAddr, lineValid);
    end
    do_reset();
  endtask

  task automatic test_basic_write();
    VCount = 10'd300;
    LY = 8'd5;
    rand_data();
    lineReq = 1'b1;
    tick();  // edge N: accept
    vectors++;
    if (lineAck !== 1'b1) begin
      errors++;
      $display("FAIL basic_ack: got lineAck=%b, expected 1", lineAck);
    end
    exp_q.push_back({8'd5, lineData0, lineData1});
    exp_writes++;
    lineReq = 1'b0;
    tick();  // N+1
    vectors++;
    if (lineAck !== 1'b0 || wrEn !== 1'b0 || dbgState !== ST_SETUP) begin
      errors++;
      $display("FAIL basic_setup: got ack=%b wrEn=%b state=%0d, expected 0/0/%0d",
               lineAck, wrEn, dbgState, ST_SETUP);
    end
    tick();  // N+2
    vectors++;
    if (wrEn !== 1'b1 || wrAddr !== 8'd5) begin
      errors++;
      $display("FAIL basic_strobe: got wrEn=%b addr=%0d, expected 1/5", wrEn, wrAddr);
    end
    tick();  // N+3 RETIRE
    vectors++;
    if (wrEn !== 1'b0 || dbgState !== ST_RETIRE || wrAddr !== 8'd5 || frameDone !== 1'b0) begin
      errors++;
      $display("FAIL basic_retire: got wrEn=%b state=%0d addr=%0d fd=%b, expected 0/%0d/5/0",
               wrEn, dbgState, wrAddr, frameDone, ST_RETIRE);
    end
    tick();
    vectors++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy: got busy=%b, expected 0", busy);
    end
  endtask

  task automatic test_guard();
    VCount = 10'd10;
    offer(8'd10, 1'b1);
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if (dbgState !== ST_GUARD || wrEn !== 1'b0) begin
        errors++;
        $display("FAIL guard_hold: got state=%0d wrEn=%b, expected %0d/0", dbgState, wrEn, ST_GUARD);
      end
    end
    VCount = 10'd11;
    tick();
    vectors++;
    if (wrEn !== 1'b1 || wrAddr !== 8'd10) begin
      errors++;
      $display("FAIL guard_release: got wrEn=%b addr=%0d, expected 1/10", wrEn, wrAddr);
    end
    wait_idle();
  endtask

  task automatic test_back_to_back();
    VCount = 10'd1;
    LY = 8'd1;
    rand_data();
    lineReq = 1'b1;
    tick();
    vectors++;
    if (lineAck !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ack1: got lineAck=%b, expected 1", lineAck);
    end
    exp_q.push_back({8'd1, lineData0, lineData1});
    exp_writes++;
    LY = 8'd2;
    rand_data();
    tick();
    vectors++;
    if (lineAck !== 1'b0) begin
      errors++;
      $display("FAIL b2b_block: got lineAck=%b, expected 0 on cycle after ack", lineAck);
    end
    tick();
    vectors++;
    if (lineAck !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ack2: got lineAck=%b, expected 1", lineAck);
    end
    exp_q.push_back({8'd2, lineData0, lineData1});
    exp_writes++;
    LY = 8'd3;
    rand_data();
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if (lineAck !== 1'b0 || busy !== 1'b1 || dbgState !== ST_GUARD) begin
        errors++;
        $display("FAIL b2b_full: got ack=%b busy=%b state=%0d, expected 0/1/%0d",
                 lineAck, busy, dbgState, ST_GUARD);
      end
    end
    VCount = 10'd300;
    tick();  // STROBE line 1
    vectors++;
    if (wrEn !== 1'b1 || wrAddr !== 8'd1) begin
      errors++;
      $display("FAIL b2b_strobe1: got wrEn=%b addr=%0d, expected 1/1", wrEn, wrAddr);
    end
    tick();  // RETIRE, pop frees a slot
    vectors++;
    if (lineAck !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ack3_early: got lineAck=%b, expected 0", lineAck);
    end
    tick();
    vectors++;
    if (lineAck !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ack3: got lineAck=%b, expected 1 after pop", lineAck);
    end
    exp_q.push_back({8'd3, lineData0, lineData1});
    exp_writes++;
    lineReq = 1'b0;
    wait_idle();
  endtask

  task automatic test_drop_and_frame();
    VCount = 10'd300;
    offer(8'd7, 1'b1);
    wait_idle();
    offer(8'd150, 1'b0);
    tick();
    offer(8'd7, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if (busy !== 1'b0 || wrEn !== 1'b0) begin
        errors++;
        $display("FAIL drop_nowrite: got busy=%b wrEn=%b, expected 0/0", busy, wrEn);
      end
    end
    offer(8'(VL - 1), 1'b1);
    for (int i = 1; i <= 5; i++) begin
      tick();
      vectors++;
      if (frameDone !== (i == 3)) begin
        errors++;
        $display("FAIL frame_done: cycle %0d got frameDone=%b, expected %b", i, frameDone, (i == 3));
      end
    end
    wait_idle();
  endtask

  task automatic test_reset_mid();
    int wr_before;
    VCount = 10'd300;
    offer(8'd20, 1'b0);
    tick();
    tick();
    vectors++;
    if (wrEn !== 1'b1 || wrAddr !== 8'd20) begin
      errors++;
      $display("FAIL rst_mid_strobe: got wrEn=%b addr=%0d, expected 1/20", wrEn, wrAddr);
    end
    wr_before = wr_count;
    reset = 1'b1;
    #1;
    vectors++;
    if ({wrEn, busy, lineAck, frameDone, dbgState, wrAddr} !== {4'b0000, ST_IDLE, 8'd0}) begin
      errors++;
      $display("FAIL rst_mid_async: got wrEn=%b busy=%b state=%0d addr=%0d, expected 0/0/0/0",
               wrEn, busy, dbgState, wrAddr);
    end
    tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    vectors++;
    if (wr_count !== wr_before || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_nowrite: got %0d writes busy=%b, expected %0d/0",
               wr_count - wr_before, busy, 0);
    end
  endtask

  task automatic test_random_offers();
    logic [7:0] model_last = 8'hFF;
    logic [7:0] ly;
    bit push;
    VCount = 10'd500;
    for (int n = 0; n < 12; n++) begin
      ly = 8'($urandom_range(0, 159));
      if (n % 4 == 3) ly = model_last;
      push = (ly < 8'(VL)) && (ly != model_last);
      if (push) model_last = ly;
      offer(ly, push);
      if (n % 3 == 2) tick();
    end
    wait_idle();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_basic_write();
    test_guard();
    test_back_to_back();
    test_drop_and_frame();
    test_reset_mid();
    test_random_offers();
    tick();
    tick();
    vectors++;
    if (exp_q.size() != 0 || wr_count != exp_writes) begin
      errors++;
      $display("FAIL final_tally: got %0d writes with %0d pending, expected %0d writes 0 pending",
               wr_count, exp_q.size(), exp_writes);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
